// File: rtl/pulse_scan_sequencer.sv
// Pulse scan sequencer: sweeps del_out over n_points, n_shots sync edges each.
// Optional phase cycling (even shot count, toggling phase) via SCAN_PHASE_CYCLE_EN.
module pulse_scan_sequencer #(
  parameter int DW           = 16,
  parameter int CW           = 16,
  parameter int SETTLE_SHOTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          sync_in,
  input  logic [DW-1:0] del_start,
  input  logic [DW-1:0] del_step,
  input  logic [CW-1:0] n_points,
  input  logic [CW-1:0] n_shots,
  output logic [DW-1:0] del_out,
  output logic [CW-1:0] point_idx,
  output logic [CW-1:0] shot_cnt,
  output logic          busy,
  output logic          point_done,
  output logic          done,
  output logic          phase
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACQ, FIN} state_t;

  localparam logic [CW-1:0] SETTLE_N = CW'(SETTLE_SHOTS);

  state_t        state_q, state_d;
  logic [DW-1:0] del_q, del_d;
  logic [DW-1:0] step_q, step_d;
  logic [CW-1:0] npts_q, npts_d;
  logic [CW-1:0] nshots_q, nshots_d;
  logic [CW-1:0] pidx_q, pidx_d;
  logic [CW-1:0] shot_q, shot_d;
  logic [CW-1:0] settle_q, settle_d;
  logic          busy_q, busy_d;
  logic          pdone_q, pdone_d;
  logic          done_q, done_d;
  logic          s1_q, s2_q, s3_q;
  logic          sync_edge;
  logic [CW-1:0] nsh_in;

  // s1/s2 resynchronise sync_in; s3 holds the previous level for edge detect
  assign sync_edge = s2_q & ~s3_q;

`ifdef SCAN_PHASE_CYCLE_EN
  logic phase_q, phase_d;
  logic acq_entry, acq_edge;

  assign nsh_in    = n_shots + {{(CW-1){1'b0}}, n_shots[0]};
  assign acq_entry = (state_d == ACQ) && (state_q != ACQ);
  assign acq_edge  = (state_q == ACQ) && sync_edge && !abort;

  always_comb begin
    phase_d = phase_q;
    if (acq_entry)     phase_d = 1'b0;
    else if (acq_edge) phase_d = ~phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;
`else
  assign nsh_in = n_shots;
  assign phase  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    del_d    = del_q;
    step_d   = step_q;
    npts_d   = npts_q;
    nshots_d = nshots_q;
    pidx_d   = pidx_q;
    shot_d   = shot_q;
    settle_d = settle_q;
    pdone_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          del_d    = del_start;
          step_d   = del_step;
          npts_d   = n_points;
          nshots_d = nsh_in;
          pidx_d   = '0;
          shot_d   = '0;
          settle_d = '0;
          if ((n_points == '0) || (nsh_in == '0)) state_d = FIN;
          else                                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_N) begin
          state_d = ACQ;
        end else if (sync_edge) begin
          settle_d = settle_q + CW'(1);
          if (settle_d == SETTLE_N) state_d = ACQ;
        end
      end
      ACQ: begin
        if (sync_edge) begin
          shot_d = shot_q + CW'(1);
          if (shot_d == nshots_q) begin
            pdone_d = 1'b1;
            if (pidx_q == npts_q - CW'(1)) begin
              state_d = FIN;
            end else begin
              pidx_d   = pidx_q + CW'(1);
              del_d    = del_q + step_q;
              shot_d   = '0;
              settle_d = '0;
              state_d  = SETTLE;
            end
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      del_d   = del_q;
      pidx_d  = pidx_q;
      shot_d  = shot_q;
      pdone_d = 1'b0;
      done_d  = 1'b0;
    end
    // busy stays up through the cycle that carries done
    busy_d = (state_d != IDLE) || ((state_q == FIN) && !abort);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      del_q    <= '0;
      step_q   <= '0;
      npts_q   <= '0;
      nshots_q <= '0;
      pidx_q   <= '0;
      shot_q   <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      pdone_q  <= 1'b0;
      done_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      del_q    <= del_d;
      step_q   <= step_d;
      npts_q   <= npts_d;
      nshots_q <= nshots_d;
      pidx_q   <= pidx_d;
      shot_q   <= shot_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      pdone_q  <= pdone_d;
      done_q   <= done_d;
      s1_q     <= sync_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
    end
  end

  assign del_out    = del_q;
  assign point_idx  = pidx_q;
  assign shot_cnt   = shot_q;
  assign busy       = busy_q;
  assign point_done = pdone_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pulse_scan_sequencer.sv
// Directed testbench for pulse_scan_sequencer (default parameters, SETTLE_SHOTS=2).
// Phase expectations follow SCAN_PHASE_CYCLE_EN when it is defined.
module tb_pulse_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        sync_in;
  logic [15:0] del_start;
  logic [15:0] del_step;
  logic [15:0] n_points;
  logic [15:0] n_shots;
  logic [15:0] del_out;
  logic [15:0] point_idx;
  logic [15:0] shot_cnt;
  logic        busy;
  logic        point_done;
  logic        done;
  logic        phase;

  int n_cmp = 0;
  int n_err = 0;
  int pd_cnt = 0;
  int done_cnt = 0;
  int pd_base;
  int done_base;
  int ns_exp;

  pulse_scan_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sync_in(sync_in), .del_start(del_start), .del_step(del_step),
    .n_points(n_points), .n_shots(n_shots), .del_out(del_out),
    .point_idx(point_idx), .shot_cnt(shot_cnt), .busy(busy),
    .point_done(point_done), .done(done), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (point_done) pd_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge is counted on the third clock after the rise.
  task automatic pulse_rise();
    sync_in = 1'b1;
    ticks(3);
  endtask

  task automatic pulse_fall();
    sync_in = 1'b0;
    ticks(3);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_rise();
      pulse_fall();
    end
  endtask

  task automatic kick(input logic [15:0] ds, input logic [15:0] dst,
                      input logic [15:0] np, input logic [15:0] nsh);
    del_start = ds;
    del_step  = dst;
    n_points  = np;
    n_shots   = nsh;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; sync_in = 1'b0;
    del_start = '0; del_step = '0; n_points = '0; n_shots = '0;
    ticks(2);
    check("rst_busy", busy, 0);
    check("rst_del", del_out, 0);
    check("rst_pidx", point_idx, 0);
    check("rst_shot", shot_cnt, 0);
    check("rst_done", done, 0);
    check("rst_pdone", point_done, 0);
    check("rst_phase", phase, 0);
    rst = 1'b0;
    tick();

    // nominal sweep 100 -> 120 -> 140
    pd_base = pd_cnt; done_base = done_cnt;
    kick(16'd100, 16'd20, 16'd3, 16'd4);
    check("nom_busy", busy, 1);
    check("nom_del0", del_out, 100);
    check("nom_pidx0", point_idx, 0);
    pulses(2);
    check("nom_settle_shot", shot_cnt, 0);
    pulses(2);
    check("nom_shot2", shot_cnt, 2);
    check("nom_phase", phase, 0);
    pulses(2);
    check("nom_del1", del_out, 120);
    check("nom_pidx1", point_idx, 1);
    check("nom_shot_clr", shot_cnt, 0);
    pulses(6);
    check("nom_del2", del_out, 140);
    check("nom_pidx2", point_idx, 2);
    pulses(5);
    pulse_rise();
    check("nom_last_pdone", point_done, 1);
    check("nom_last_shot", shot_cnt, 4);
    check("nom_last_nodone", done, 0);
    tick();
    check("nom_done", done, 1);
    check("nom_busy_done", busy, 1);
    tick();
    check("nom_done_end", done, 0);
    check("nom_busy_end", busy, 0);
    sync_in = 1'b0;
    ticks(2);
    pulses(2);
    check("nom_pd_count", pd_cnt - pd_base, 3);
    check("nom_done_count", done_cnt - done_base, 1);
    check("nom_hold_del", del_out, 140);
    check("nom_hold_pidx", point_idx, 2);
    check("nom_hold_shot", shot_cnt, 4);
    check("nom_hold_busy", busy, 0);

    // zero point count
    pd_base = pd_cnt; done_base = done_cnt;
    kick(16'd55, 16'd5, 16'd0, 16'd4);
    check("zero_busy", busy, 1);
    check("zero_del", del_out, 55);
    check("zero_nodone_yet", done, 0);
    tick();
    check("zero_done", done, 1);
    tick();
    check("zero_busy_end", busy, 0);
    check("zero_pd", pd_cnt - pd_base, 0);
    check("zero_done_count", done_cnt - done_base, 1);

    // abort during ACQ of point 1
    pd_base = pd_cnt; done_base = done_cnt;
    kick(16'd100, 16'd20, 16'd3, 16'd4);
    pulses(10);
    check("ab_shot", shot_cnt, 2);
    check("ab_pidx", point_idx, 1);
    check("ab_del_pre", del_out, 120);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_del", del_out, 120);
    pulses(2);
    check("ab_after_shot", shot_cnt, 2);
    check("ab_after_del", del_out, 120);
    check("ab_after_busy", busy, 0);
    check("ab_pd", pd_cnt - pd_base, 1);
    check("ab_nodone", done_cnt - done_base, 0);

    // delay wrap
    kick(16'hFFF0, 16'h0020, 16'd2, 16'd2);
    check("wrap_del0", del_out, 16'hFFF0);
    pulses(4);
    check("wrap_del1", del_out, 16'h0010);
    check("wrap_pidx1", point_idx, 1);
    pulses(4);
    check("wrap_busy_end", busy, 0);
    check("wrap_del_hold", del_out, 16'h0010);

    // start with abort in the same cycle
    del_start = 16'd777;
    n_points  = 16'd1;
    n_shots   = 16'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("coll_busy", busy, 0);
    tick();
    check("coll_busy2", busy, 0);
    check("coll_del", del_out, 16'h0010);

    // start while busy and mid-sweep n_shots change
    pd_base = pd_cnt; done_base = done_cnt;
    kick(16'd200, 16'd10, 16'd1, 16'd2);
    n_shots   = 16'd5;
    del_start = 16'd999;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_del", del_out, 200);
    check("busy_start_pidx", point_idx, 0);
    pulses(4);
    check("mid_shot", shot_cnt, 2);
    check("mid_pd", pd_cnt - pd_base, 1);
    check("mid_done", done_cnt - done_base, 1);
    check("mid_busy", busy, 0);

    // phase cycling with odd n_shots
`ifdef SCAN_PHASE_CYCLE_EN
    ns_exp = 4;
`else
    ns_exp = 3;
`endif
    pd_base = pd_cnt; done_base = done_cnt;
    kick(16'd7, 16'd1, 16'd1, 16'd3);
    pulses(2);
    for (int i = 0; i < ns_exp; i++) begin
      pulses(1);
`ifdef SCAN_PHASE_CYCLE_EN
      check($sformatf("ph_phase%0d", i), phase, (i % 2 == 0) ? 1 : 0);
`else
      check($sformatf("ph_phase%0d", i), phase, 0);
`endif
    end
    check("ph_shot", shot_cnt, ns_exp);
    check("ph_pd", pd_cnt - pd_base, 1);
    check("ph_done", done_cnt - done_base, 1);
    check("ph_busy", busy, 0);

    // reset mid-sweep
    kick(16'd300, 16'd1, 16'd4, 16'd4);
    pulses(3);
    check("mr_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_del", del_out, 0);
    check("mr_busy", busy, 0);
    check("mr_shot", shot_cnt, 0);
    check("mr_pidx", point_idx, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
